// File: rtl/rgb_sequence_controller_if.sv
// Step-table write port of the RGB sequencer: valid/ready handshake plus one table entry.
interface rgb_sequence_controller_if;
    logic       valid;
    logic       ready;
    logic [2:0] addr;
    logic [2:0] color1;
    logic [2:0] color2;
    logic [3:0] dwell;

    modport master (output valid, addr, color1, color2, dwell, input ready);
    modport slave  (input valid, addr, color1, color2, dwell, output ready);
endinterface

// File: rtl/rgb_sequence_controller.sv
// Plays an 8-entry colour/dwell table onto two RGB LEDs, with a tick prescaler and
// brightness PWM. The table is writable only while idle.
module rgb_sequence_controller #(
    parameter int unsigned TICK_DIV = 50_000_000,
    parameter int unsigned PWM_BITS = 4,
    parameter int unsigned STEPS    = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    rgb_sequence_controller_if.slave  cfg,
    input  logic [2:0]                seq_last,
    input  logic                      loop_en,
    input  logic                      start,
    input  logic                      stop,
    input  logic [PWM_BITS-1:0]       brightness,
    output logic                      busy,
    output logic                      done,
    output logic [2:0]                step_idx,
    output logic [2:0]                RGB1,
    output logic [2:0]                RGB2
);

    localparam int unsigned PrescW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PrescW-1:0] PrescLast = PrescW'(TICK_DIV - 1);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e              state_q, state_d;
    logic [2:0]          step_q, step_d;
    logic [3:0]          dwell_cnt_q, dwell_cnt_d;
    logic [PrescW-1:0]   presc_q, presc_d;
    logic [2:0]          last_q, last_d;
    logic                loop_q, loop_d;
    logic                done_q, done_d;
    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic [2:0]          rgb1_q, rgb1_d;
    logic [2:0]          rgb2_q, rgb2_d;

    logic [2:0] color1_tab_q [STEPS];
    logic [2:0] color2_tab_q [STEPS];
    logic [3:0] dwell_tab_q  [STEPS];

    logic       tick;
    logic       tab_we;
    logic       pwm_on;
    logic [2:0] next_idx;

    assign tick     = (presc_q == PrescLast);
    assign next_idx = step_q + 3'd1;
    assign pwm_on   = (&brightness) | (pwm_cnt_q < brightness);

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        dwell_cnt_d = dwell_cnt_q;
        presc_d     = presc_q;
        last_d      = last_q;
        loop_d      = loop_q;
        done_d      = 1'b0;
        tab_we      = 1'b0;
        unique case (state_q)
            StIdle: begin
                tab_we  = cfg.valid;
                presc_d = '0;
                if (start && !stop) begin
                    state_d     = StRun;
                    last_d      = seq_last;
                    loop_d      = loop_en;
                    step_d      = 3'd0;
                    dwell_cnt_d = dwell_tab_q[0];
                end
            end
            StRun: begin
                presc_d = tick ? '0 : presc_q + PrescW'(1);
                // Stop takes priority over any tick-driven step or completion.
                if (stop) begin
                    state_d = StIdle;
                    step_d  = 3'd0;
                end else if (tick) begin
                    if (dwell_cnt_q != 4'd0) begin
                        dwell_cnt_d = dwell_cnt_q - 4'd1;
                    end else if (step_q != last_q) begin
                        step_d      = next_idx;
                        dwell_cnt_d = dwell_tab_q[next_idx];
                    end else if (loop_q) begin
                        step_d      = 3'd0;
                        dwell_cnt_d = dwell_tab_q[0];
                    end else begin
                        state_d = StIdle;
                        step_d  = 3'd0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Gating on the next state as well blanks the LEDs on the first idle cycle.
    always_comb begin
        rgb1_d = 3'd0;
        rgb2_d = 3'd0;
        if (state_q == StRun && state_d == StRun) begin
            rgb1_d = color1_tab_q[step_q] & {3{pwm_on}};
            rgb2_d = color2_tab_q[step_q] & {3{pwm_on}};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            step_q      <= 3'd0;
            dwell_cnt_q <= 4'd0;
            presc_q     <= '0;
            last_q      <= 3'd0;
            loop_q      <= 1'b0;
            done_q      <= 1'b0;
            pwm_cnt_q   <= '0;
            rgb1_q      <= 3'd0;
            rgb2_q      <= 3'd0;
            for (int k = 0; k < STEPS; k++) begin
                color1_tab_q[k] <= 3'(k);
                color2_tab_q[k] <= 3'(k);
                dwell_tab_q[k]  <= 4'd2;
            end
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            dwell_cnt_q <= dwell_cnt_d;
            presc_q     <= presc_d;
            last_q      <= last_d;
            loop_q      <= loop_d;
            done_q      <= done_d;
            pwm_cnt_q   <= pwm_cnt_q + PWM_BITS'(1);
            rgb1_q      <= rgb1_d;
            rgb2_q      <= rgb2_d;
            if (tab_we) begin
                color1_tab_q[cfg.addr] <= cfg.color1;
                color2_tab_q[cfg.addr] <= cfg.color2;
                dwell_tab_q[cfg.addr]  <= cfg.dwell;
            end
        end
    end

    assign cfg.ready = (state_q == StIdle);
    assign busy      = (state_q == StRun);
    assign done      = done_q;
    assign step_idx  = step_q;
    assign RGB1      = rgb1_q;
    assign RGB2      = rgb2_q;

endmodule
